// File: rtl/reg_file_pkg.sv
// Shared constants, write-back queue entry type and pointer helpers for the
// register file with write-back queue.
//   DATA_W  register / data width
//   ADDR_W  register address width
//   NREG    number of architectural registers
//   QDEPTH  write-back queue entries
//   NLOOK   number of forwarding lookup ports on the queue
package reg_file_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int QDEPTH = 2;
    localparam int NLOOK  = 2;

    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

    // Increment modulo QDEPTH; works for non-power-of-two depths too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == QDEPTH - 1)
            return '0;
        return p + 1'b1;
    endfunction

    // p + k modulo QDEPTH, for k in 0..QDEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [PTR_W:0]   k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + k;
        if (int'(s) >= QDEPTH)
            s = s - (PTR_W+1)'(QDEPTH);
        return s[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/reg_file_wbq_wb_queue.sv
// QDEPTH-entry write-back FIFO with youngest-match forwarding lookups.
//   clk, rstn          clock, asynchronous active-low reset
//   enq_vld/addr/data  write request; accepted when !full
//   deq_en             allows the head to retire this cycle
//   full, empty        occupancy flags (registered state only)
//   cmt_vld/addr/data  head entry retiring on this edge
//   lk_addr            per-port lookup address
//   lk_hit, lk_data    youngest queued entry matching lk_addr
module wb_queue
    import reg_file_pkg::*;
(
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enq_vld,
    input  logic [ADDR_W-1:0]             enq_addr,
    input  logic [DATA_W-1:0]             enq_data,
    input  logic                          deq_en,
    output logic                          full,
    output logic                          empty,
    output logic                          cmt_vld,
    output logic [ADDR_W-1:0]             cmt_addr,
    output logic [DATA_W-1:0]             cmt_data,
    input  logic [NLOOK-1:0][ADDR_W-1:0]  lk_addr,
    output logic [NLOOK-1:0]              lk_hit,
    output logic [NLOOK-1:0][DATA_W-1:0]  lk_data
);

    wbq_entry_t       ent [QDEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             enq;

    assign full     = (count == CNT_W'(QDEPTH));
    assign empty    = (count == '0);
    assign enq      = enq_vld && !full;
    assign cmt_vld  = deq_en && !empty;
    assign cmt_addr = ent[head].addr;
    assign cmt_data = ent[head].data;

    // The head being cleared and the tail being filled are never the same
    // slot: enqueue needs count<QDEPTH and commit needs count>0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++)
                ent[i] <= '0;
        end else begin
            if (cmt_vld) begin
                ent[head].valid <= 1'b0;
                head            <= ptr_inc(head);
            end
            if (enq) begin
                ent[tail] <= '{valid: 1'b1, addr: enq_addr, data: enq_data};
                tail      <= ptr_inc(tail);
            end
            case ({enq, cmt_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest; a later match overrides, so the youngest wins.
    for (genvar p = 0; p < NLOOK; p++) begin : g_look
        logic              hit;
        logic [DATA_W-1:0] dat;
        always_comb begin
            hit = 1'b0;
            dat = '0;
            for (int k = 0; k < QDEPTH; k++) begin
                if (ent[ptr_add(head, (PTR_W+1)'(k))].valid &&
                    ent[ptr_add(head, (PTR_W+1)'(k))].addr == lk_addr[p]) begin
                    hit = 1'b1;
                    dat = ent[ptr_add(head, (PTR_W+1)'(k))].data;
                end
            end
        end
        assign lk_hit[p]  = hit;
        assign lk_data[p] = dat;
    end

endmodule

// File: rtl/reg_file_wbq.sv
// Register file with write-back queue: ALU results are queued and retired
// to the array one per Commit_en cycle; operand reads see queued values.
//   clk, rstn             clock, asynchronous active-low reset
//   Readreg1/2            operand read addresses
//   Readdata1/2           operands, forwarded from the queue (combinational)
//   RegWrite/Writereg/Writedata  write request from the ALU
//   Wr_ready              queue can accept a write this cycle
//   Commit_en             lets the queue head retire this cycle
//   Pending               queue non-empty
//   Dispreg/Dispdata      committed-only display read (combinational)
module reg_file_wbq
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] Readreg1,
    input  logic [ADDR_W-1:0] Readreg2,
    output logic [DATA_W-1:0] Readdata1,
    output logic [DATA_W-1:0] Readdata2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Writereg,
    input  logic [DATA_W-1:0] Writedata,
    output logic              Wr_ready,
    input  logic              Commit_en,
    output logic              Pending,
    input  logic [ADDR_W-1:0] Dispreg,
    output logic [DATA_W-1:0] Dispdata
);

    logic [NREG-1:0][DATA_W-1:0]  regs;
    logic                         full, empty;
    logic                         cmt_vld;
    logic [ADDR_W-1:0]            cmt_addr;
    logic [DATA_W-1:0]            cmt_data;
    logic [NLOOK-1:0][ADDR_W-1:0] lk_addr;
    logic [NLOOK-1:0]             lk_hit;
    logic [NLOOK-1:0][DATA_W-1:0] lk_data;

    assign lk_addr = {Readreg2, Readreg1};

    wb_queue u_wbq (
        .clk      (clk),
        .rstn     (rstn),
        .enq_vld  (RegWrite),
        .enq_addr (Writereg),
        .enq_data (Writedata),
        .deq_en   (Commit_en),
        .full     (full),
        .empty    (empty),
        .cmt_vld  (cmt_vld),
        .cmt_addr (cmt_addr),
        .cmt_data (cmt_data),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            regs <= '0;
        else if (cmt_vld)
            regs[cmt_addr] <= cmt_data;
    end

    assign Wr_ready  = !full;
    assign Pending   = !empty;
    assign Readdata1 = lk_hit[0] ? lk_data[0] : regs[Readreg1];
    assign Readdata2 = lk_hit[1] ? lk_data[1] : regs[Readreg2];
    assign Dispdata  = regs[Dispreg];

endmodule
